// File: rtl/stopwatch_sequencer.sv
// Stopwatch control sequencer: turns debounced button levels into run/halt/split
// control. Generates the count tick and clear pulse for the external BCD counter
// and owns the display hold register.
module stopwatch_sequencer #(
    parameter int TICK_DIV = 500000,
    parameter int DIV_W    = 19
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        stop,
    input  logic        split,
    input  logic        zero,
    input  logic [15:0] live_time,
    output logic        count_en,
    output logic        count_clr,
    output logic [15:0] displayed_time,
    output logic        led
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_SPLIT = 2'd2;
    localparam logic [1:0] ST_HALT  = 2'd3;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

    logic [1:0]       state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [3:0]       btn_q, btn_d;
    logic             armed_q, armed_d;
    logic             count_en_q, count_en_d;
    logic             count_clr_q, count_clr_d;
    logic [15:0]      disp_q, disp_d;
    logic             led_q, led_d;

    logic [3:0] btn_now;
    logic [3:0] rise;
    logic       ev_zero, ev_stop, ev_split, ev_start;
    logic       running_d;

    // Rising-edge detect with fixed priority zero > stop > split > start.
    // The first cycle after reset is blanked so a button held through reset
    // does not look like a fresh press (history is cleared by reset).
    always_comb begin
        btn_now  = {zero, stop, split, start};
        rise     = btn_now & ~btn_q & {4{armed_q}};
        ev_zero  = rise[3];
        ev_stop  = rise[2] & ~rise[3];
        ev_split = rise[1] & ~(|rise[3:2]);
        ev_start = rise[0] & ~(|rise[3:1]);
        btn_d    = btn_now;
        armed_d  = 1'b1;
    end

    // Next state and clear request; lower-priority edges are simply dropped.
    always_comb begin
        state_d     = state_q;
        count_clr_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (ev_zero) begin
                    count_clr_d = 1'b1;
                end else if (ev_start) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (ev_stop) begin
                    state_d = ST_HALT;
                end else if (ev_split) begin
                    state_d = ST_SPLIT;
                end
            end
            ST_SPLIT: begin
                if (ev_stop) begin
                    state_d = ST_HALT;
                end else if (ev_split) begin
                    state_d = ST_RUN;
                end
            end
            ST_HALT: begin
                if (ev_zero) begin
                    state_d     = ST_IDLE;
                    count_clr_d = 1'b1;
                end else if (ev_start) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Tick divider: advances only when the next state is timing, so a stop
    // landing on the wrap edge leaves the wrap pending for the resume.
    always_comb begin
        running_d  = (state_d == ST_RUN) || (state_d == ST_SPLIT);
        div_d      = div_q;
        count_en_d = 1'b0;
        if (running_d) begin
            if (div_q == DIV_LAST) begin
                div_d      = '0;
                count_en_d = 1'b1;
            end else begin
                div_d = div_q + DIV_ONE;
            end
        end else if (count_clr_d || (state_d == ST_IDLE)) begin
            div_d = '0;
        end
        led_d = running_d;
    end

    // Display register doubles as the split hold: load live_time on split
    // entry, hold while in SPLIT, otherwise track live_time.
    always_comb begin
        if (state_d == ST_SPLIT) begin
            if (state_q != ST_SPLIT) begin
                disp_d = live_time;
            end else begin
                disp_d = disp_q;
            end
        end else begin
            disp_d = live_time;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            div_q       <= '0;
            btn_q       <= '0;
            armed_q     <= 1'b0;
            count_en_q  <= 1'b0;
            count_clr_q <= 1'b0;
            disp_q      <= 16'h0000;
            led_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            btn_q       <= btn_d;
            armed_q     <= armed_d;
            count_en_q  <= count_en_d;
            count_clr_q <= count_clr_d;
            disp_q      <= disp_d;
            led_q       <= led_d;
        end
    end

    assign count_en       = count_en_q;
    assign count_clr      = count_clr_q;
    assign displayed_time = disp_q;
    assign led            = led_q;

endmodule
